serial_packet_decoder: RTL and testbench
========================================

Name: serial_packet_decoder

Overview:
- Sits between the UART receiver and the CPU's packet/DMA consumer.
- Parses the received byte stream into framed packets: magic byte, 16-bit big-endian length, then payload.
- Emits payload bytes on a valid/ready stream through an internal FIFO, with last-byte marking and a per-packet valid pulse. This pulse drives serial_to_packet_valid.
- The UART side has no backpressure, so the FIFO absorbs consumer stalls; overflow is flagged.

Parameters:
- MAGIC, 8'h51, header byte that starts a packet.
- MAX_LEN, 1024, largest accepted payload length; longer packets are discarded.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single system clock.
- clear_n  in  1  asynchronous active-low reset.
- in_valid  in  1  one-cycle strobe, in_data holds a received byte.
- in_data  in  8  received byte.
- out_valid  out  1  FIFO non-empty.
- out_data  out  8  payload byte at FIFO head.
- out_last  out  1  head byte is the final payload byte of its packet.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- packet_valid  out  1  one-cycle pulse when a complete packet's final byte enters the FIFO.
- length_error  out  1  one-cycle pulse when a header length exceeds MAX_LEN.
- overflow_error  out  1  one-cycle pulse when a payload byte arrives while the FIFO is full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; FIFO empty; counters 0.
- Reset asserted mid-packet discards the partial packet and all FIFO contents immediately.
- FSM advances only on cycles with in_valid=1. States and transitions:
  - IDLE: byte==MAGIC goes to LEN_HI; any other byte is ignored and the FSM stays in IDLE.
  - LEN_HI: latch len[15:8], go to LEN_LO.
  - LEN_LO: latch len[7:0], then:
    - len==0: go to IDLE; no pulse, no output.
    - len>MAX_LEN: pulse length_error, load remaining=len, go to DISCARD.
    - otherwise: load remaining=len, go to DATA.
  - DATA: push {byte, last=(remaining==1)} into the FIFO and decrement remaining. When remaining reaches 0, go to IDLE (CHECK if the checksum option is enabled) and pulse packet_valid on that same push cycle.
  - DISCARD: decrement remaining per byte without pushing; at 0 go to IDLE.
- Pulses are registered: asserted the cycle after the triggering in_valid.
- Latency: in_valid of a DATA byte to out_valid is 1 cycle when the FIFO is empty.
- FIFO full on a DATA byte:
  - Byte dropped, overflow_error pulsed, remaining still decrements so framing stays aligned.
  - If the dropped byte was the last byte, packet_valid is still pulsed but no last byte reaches the consumer; the consumer relies on overflow_error.
- Simultaneous push and pop: allowed when full or empty. Full + pop + push yields no overflow; the count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap-around; full = MSBs differ and the rest are equal.
- out_data/out_last are stable while out_valid && !out_ready.
- remaining is 16 bits; it never underflows because it is only decremented when non-zero.

Optional Feature:
- Macro: SERIAL_PACKET_CHECKSUM_EN.
- With it defined:
  - Running XOR of all payload bytes.
  - After the final payload byte, state CHECK consumes one extra byte.
  - packet_valid pulses only when that byte equals the XOR; otherwise a checksum_error output (1 bit, one-cycle pulse) fires.
  - Payload bytes are already in the FIFO either way; the consumer discards on checksum_error.
  - Len==0 packets also carry a checksum byte (expected 8'h00).
- Without it: no CHECK state, no checksum_error port; packet_valid pulses on the final payload push.

Decomposition:
- Shared package serial_packet_pkg:
  - FSM state enum (IDLE, LEN_HI, LEN_LO, DATA, DISCARD, CHECK).
  - Default MAGIC, MAX_LEN.
  - Byte/length width constants.
- One natural sub-module: sync_fifo (width 9 = {last, data}, depth FIFO_DEPTH, push/pop/full/empty).

Test Plan:
- Bytes 51 00 03 AA BB CC, out_ready=1 -> out_data AA,BB,CC with out_last only on CC; packet_valid one pulse; busy back to 0.
- Bytes 12 51 00 00 then 51 00 01 7E -> leading 12 ignored; zero-length packet produces nothing; then single output 7E with out_last=1, one packet_valid total.
- Header 51 04 01 (len 1025 > 1024) then 1025 payload bytes, then 51 00 01 55 -> length_error once, no output during discard; then 55 emitted correctly.
- FIFO_DEPTH=8, out_ready=0, packet of 10 bytes 00..09 -> 8 bytes stored, overflow_error pulses twice; release out_ready -> 00..07 drained, none with out_last.
- Assert clear_n=0 after 51 00 05 11 22 -> FIFO empty, out_valid=0, busy=0 immediately; next 51 00 01 33 yields 33 normally.
- With SERIAL_PACKET_CHECKSUM_EN: 51 00 02 0F F0 FF -> packet_valid pulse; 51 00 02 0F F0 00 -> checksum_error pulse, no packet_valid.

Source files
------------

// File: rtl/serial_packet_pkg.sv
// Shared types and constants for the serial packet decoder.
// Contents: byte/length widths, default header byte and length limit,
// decoder FSM state enum, and the FIFO entry payload struct.
package serial_packet_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned DEF_MAX_LEN = 1024;
    localparam logic [BYTE_W-1:0] DEF_MAGIC = 8'h51;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_DISCARD,
        ST_CHECK
    } state_t;

    // One FIFO entry: payload byte plus end-of-packet marker.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Ports: clock, clear_n (async active-low reset), i_push/i_wdata write side,
// i_pop read side, o_rdata head entry, o_full, o_empty.
// A push while full is accepted only if the head is popped in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/serial_packet_decoder.sv
// Framed packet parser between a UART receiver and a packet consumer.
// Frame: MAGIC, length[15:8], length[7:0], payload (plus checksum byte when
// SERIAL_PACKET_CHECKSUM_EN is defined).
// Ports: clock, clear_n (async active-low reset); in_valid/in_data byte input;
// out_valid/out_data/out_last/out_ready payload stream; packet_valid,
// length_error, overflow_error (and checksum_error) one-cycle pulses; busy.
module serial_packet_decoder
    import serial_packet_pkg::*;
#(
    parameter logic [BYTE_W-1:0] MAGIC      = DEF_MAGIC,
    parameter int unsigned       MAX_LEN    = DEF_MAX_LEN,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              packet_valid,
    output logic              length_error,
    output logic              overflow_error,
`ifdef SERIAL_PACKET_CHECKSUM_EN
    output logic              checksum_error,
`endif
    output logic              busy
);

    state_t            r_state, w_state_nxt;
    logic [BYTE_W-1:0] r_len_hi, w_len_hi_nxt;
    logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
    logic              r_pkt, w_pkt_nxt;
    logic              r_lerr, w_lerr_nxt;
    logic              r_ovf, w_ovf_nxt;
`ifdef SERIAL_PACKET_CHECKSUM_EN
    logic [BYTE_W-1:0] r_xor, w_xor_nxt;
    logic              r_cerr, w_cerr_nxt;
`endif

    logic [LEN_W-1:0]  w_len;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    entry_t            w_wentry;
    entry_t            w_rentry;

    assign w_len     = {r_len_hi, in_data};
    assign w_pop     = out_valid && out_ready;
    assign out_valid = !w_empty;
    assign out_data  = w_rentry.data;
    assign out_last  = w_rentry.last;
    assign busy      = (r_state != ST_IDLE);

    assign packet_valid   = r_pkt;
    assign length_error   = r_lerr;
    assign overflow_error = r_ovf;
`ifdef SERIAL_PACKET_CHECKSUM_EN
    assign checksum_error = r_cerr;
`endif

    // State and datapath registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_len_hi    <= '0;
            r_remaining <= '0;
            r_pkt       <= 1'b0;
            r_lerr      <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef SERIAL_PACKET_CHECKSUM_EN
            r_xor       <= '0;
            r_cerr      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_len_hi    <= w_len_hi_nxt;
            r_remaining <= w_remaining_nxt;
            r_pkt       <= w_pkt_nxt;
            r_lerr      <= w_lerr_nxt;
            r_ovf       <= w_ovf_nxt;
`ifdef SERIAL_PACKET_CHECKSUM_EN
            r_xor       <= w_xor_nxt;
            r_cerr      <= w_cerr_nxt;
`endif
        end
    end

    // Next-state, FIFO push and pulse generation; advances only on in_valid.
    always_comb begin
        w_state_nxt     = r_state;
        w_len_hi_nxt    = r_len_hi;
        w_remaining_nxt = r_remaining;
        w_pkt_nxt       = 1'b0;
        w_lerr_nxt      = 1'b0;
        w_ovf_nxt       = 1'b0;
        w_push          = 1'b0;
        w_wentry.data   = in_data;
        w_wentry.last   = (r_remaining == LEN_W'(1));
`ifdef SERIAL_PACKET_CHECKSUM_EN
        w_xor_nxt       = r_xor;
        w_cerr_nxt      = 1'b0;
`endif
        if (in_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_data == MAGIC) w_state_nxt = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    w_len_hi_nxt = in_data;
                    w_state_nxt  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
`ifdef SERIAL_PACKET_CHECKSUM_EN
                    w_xor_nxt = '0;
`endif
                    w_remaining_nxt = w_len;
                    if (w_len == '0) begin
`ifdef SERIAL_PACKET_CHECKSUM_EN
                        w_state_nxt = ST_CHECK;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else if (w_len > LEN_W'(MAX_LEN)) begin
                        w_lerr_nxt  = 1'b1;
                        w_state_nxt = ST_DISCARD;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // A full FIFO still takes the byte if the head leaves this cycle.
                    if (!w_full || w_pop) w_push    = 1'b1;
                    else                  w_ovf_nxt = 1'b1;
`ifdef SERIAL_PACKET_CHECKSUM_EN
                    w_xor_nxt = r_xor ^ in_data;
`endif
                    if (r_remaining != '0) w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
`ifdef SERIAL_PACKET_CHECKSUM_EN
                        w_state_nxt = ST_CHECK;
`else
                        w_pkt_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
                ST_DISCARD: begin
                    if (r_remaining != '0) w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining <= LEN_W'(1)) w_state_nxt = ST_IDLE;
                end
                ST_CHECK: begin
`ifdef SERIAL_PACKET_CHECKSUM_EN
                    if (in_data == r_xor) w_pkt_nxt  = 1'b1;
                    else                  w_cerr_nxt = 1'b1;
`endif
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear_n (clear_n),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rentry),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_serial_packet_decoder.sv
// Scoreboard bench for serial_packet_decoder: stimulus pushes expected
// {last,data} entries, a negedge monitor pops and compares accepted outputs.
module tb_serial_packet_decoder;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       packet_valid;
    logic       length_error;
    logic       overflow_error;
    logic       busy;
`ifdef SERIAL_PACKET_CHECKSUM_EN
    logic       checksum_error;
`endif

    int checks = 0;
    int errors = 0;
    int n_pkt  = 0;
    int n_lerr = 0;
    int n_ovf  = 0;
    int n_cerr = 0;
    int b_pkt, b_lerr, b_ovf, b_cerr;
    logic [8:0] sb[$];

    always #5 clock = ~clock;

    serial_packet_decoder dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .packet_valid   (packet_valid),
        .length_error   (length_error),
        .overflow_error (overflow_error),
`ifdef SERIAL_PACKET_CHECKSUM_EN
        .checksum_error (checksum_error),
`endif
        .busy           (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: compare every accepted head entry and count pulses.
    always @(negedge clock) begin
        if (clear_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", int'({out_last, out_data}), -1);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("out_entry", int'({out_last, out_data}), int'(e));
                end
            end
            if (packet_valid)   n_pkt++;
            if (length_error)   n_lerr++;
            if (overflow_error) n_ovf++;
`ifdef SERIAL_PACKET_CHECKSUM_EN
            if (checksum_error) n_cerr++;
`endif
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic last);
        sb.push_back({last, b});
    endtask

    task automatic mark();
        b_pkt  = n_pkt;
        b_lerr = n_lerr;
        b_ovf  = n_ovf;
        b_cerr = n_cerr;
    endtask

    // Bounded drain, then compare pulse counts accumulated since mark().
    task automatic finish_test(input string name, input int e_pkt, input int e_lerr,
                               input int e_ovf, input int e_cerr);
        int budget;
        budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        repeat (3) @(posedge clock);
        #1;
        check({name, "_drained"},  sb.size(), 0);
        check({name, "_pkt"},      n_pkt - b_pkt, e_pkt);
        check({name, "_lerr"},     n_lerr - b_lerr, e_lerr);
        check({name, "_ovf"},      n_ovf - b_ovf, e_ovf);
        check({name, "_cerr"},     n_cerr - b_cerr, e_cerr);
        check({name, "_busy"},     int'(busy), 0);
        check({name, "_outvalid"}, int'(out_valid), 0);
        sb.delete();
    endtask

    initial begin
        clear_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_out_last",  int'(out_last), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_pulses",    int'({packet_valid, length_error, overflow_error}), 0);
        clear_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic 3-byte packet.
        mark();
        expect_byte(8'hAA, 1'b0);
        expect_byte(8'hBB, 1'b0);
        expect_byte(8'hCC, 1'b1);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        finish_test("basic", 1, 0, 0, 0);

        // Junk, zero-length packet, then single-byte packet.
        mark();
        send_byte(8'h12);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h00);
        check("zero_len_busy", int'(busy), 0);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h01);
        expect_byte(8'h7E, 1'b1);
        send_byte(8'h7E);
        check("latency_out_valid", int'(out_valid), 1);
        finish_test("single", 1, 0, 0, 0);

        // Oversize packet is discarded, next packet is intact.
        mark();
        send_byte(8'h51); send_byte(8'h04); send_byte(8'h01);
        for (int i = 0; i < 1025; i++) begin
            send_byte(8'(i));
        end
        check("discard_done_busy", int'(busy), 0);
        expect_byte(8'h55, 1'b1);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55);
        finish_test("oversize", 1, 1, 0, 0);

        // Overflow: 10 bytes into an 8-deep FIFO with the consumer stalled.
        mark();
        out_ready = 1'b0;
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h0A);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_byte(8'(i), 1'b0);
            send_byte(8'(i));
        end
        repeat (2) @(posedge clock);
        #1;
        check("ovf_head_held", int'(out_data), 0);
        out_ready = 1'b1;
        finish_test("overflow", 1, 0, 2, 0);

        // Reset mid-packet flushes everything immediately.
        mark();
        out_ready = 1'b0;
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22);
        check("pre_rst_out_valid", int'(out_valid), 1);
        clear_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy",      int'(busy), 0);
        @(posedge clock);
        #1;
        clear_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        expect_byte(8'h33, 1'b1);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h33);
        finish_test("reset", 1, 0, 0, 0);

`ifdef SERIAL_PACKET_CHECKSUM_EN
        // Good and bad checksums.
        mark();
        expect_byte(8'h0F, 1'b0);
        expect_byte(8'hF0, 1'b1);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFF);
        finish_test("csum_good", 1, 0, 0, 0);

        mark();
        expect_byte(8'h0F, 1'b0);
        expect_byte(8'hF0, 1'b1);
        send_byte(8'h51); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h00);
        finish_test("csum_bad", 0, 0, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
